// File: rtl/out_port_pkg.sv
// Shared types, default sizing and helpers for the egress PHV serializer.
// Imported by phv_fifo and out_port_serializer.
package out_port_pkg;

  localparam int PHV_BYTES_DEF  = 128;
  localparam int BEAT_BYTES_DEF = 32;

  localparam int BEATS_MAX  = PHV_BYTES_DEF / BEAT_BYTES_DEF;
  localparam int LEN_W      = $clog2(PHV_BYTES_DEF + 1);
  localparam int BEAT_IDX_W = (BEATS_MAX > 1) ? $clog2(BEATS_MAX) : 1;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_t;

  function automatic int unsigned beats_for_len(
    input int unsigned len,
    input int unsigned bb
  );
    return (len + bb - 1) / bb;
  endfunction

endpackage

// File: rtl/phv_fifo.sv
// Generic synchronous FIFO; entry readable the cycle after its push.
// Ports: clock, reset_n, push/wr_data, pop/rd_data, full, empty, count.
module phv_fifo
  import out_port_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [OCC_W-1:0] occ;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A full FIFO refuses pushes even if a pop frees space this cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (occ == OCC_W'(DEPTH));
  assign empty   = (occ == '0);
  assign count   = occ;
  assign rd_data = mem[rp];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      if (do_push) wp <= nxt(wp);
      if (do_pop)  rp <= nxt(rp);
      unique case ({do_push, do_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wp] <= wr_data;
  end

endmodule

// File: rtl/out_port_serializer.sv
// Egress port: buffers whole PHVs and emits them as keep-qualified beats.
// Ports: PHV input (data/len/valid/ready), beat output, emitted-PHV count.
module out_port_serializer
  import out_port_pkg::*;
#(
  parameter int PHV_BYTES  = PHV_BYTES_DEF,
  parameter int BEAT_BYTES = BEAT_BYTES_DEF,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 32
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [PHV_BYTES*8-1:0]             io_phv_in_data,
  input  logic [$clog2(PHV_BYTES+1)-1:0]     io_phv_in_len,
  input  logic                               io_phv_in_valid,
  output logic                               io_phv_in_ready,
  output logic [BEAT_BYTES*8-1:0]            io_out_data,
  output logic [BEAT_BYTES-1:0]              io_out_keep,
  output logic                               io_out_first,
  output logic                               io_out_last,
  output logic                               io_out_valid,
  input  logic                               io_out_ready,
  output logic [CNT_W-1:0]                   io_phv_count
);

  localparam int BEATS = PHV_BYTES / BEAT_BYTES;
  localparam int L_W   = $clog2(PHV_BYTES + 1);
  localparam int K_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int D_W   = PHV_BYTES * 8;
  localparam int ENT_W = D_W + L_W;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int BB_W  = BEAT_BYTES * 8;

  logic              fifo_full;
  logic              fifo_empty;
  logic [OCC_W-1:0]  occ;
  logic              push;
  logic              pop;
  logic [L_W-1:0]    eff_len;
  logic [ENT_W-1:0]  wr_ent;
  logic [ENT_W-1:0]  head;
  logic [D_W-1:0]    head_data;
  logic [L_W-1:0]    head_len;
  ser_state_t        state;
  logic [K_W-1:0]    k;
  logic [CNT_W-1:0]  cnt;
  logic              xfer;
  logic              at_last;
  logic              busy_nxt;
  logic [BEAT_BYTES-1:0] keep_c;
  logic [BB_W-1:0]   beat_c;

  // Length 0 encodes a full PHV; store the explicit byte count.
  assign eff_len = (io_phv_in_len == '0) ? L_W'(PHV_BYTES)
                                         : io_phv_in_len;
  assign wr_ent  = {io_phv_in_data, eff_len};

  assign io_phv_in_ready = reset_n & ~fifo_full;
  assign push            = io_phv_in_valid & io_phv_in_ready;

  phv_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .wr_data (wr_ent),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (occ)
  );

  assign {head_data, head_len} = head;

  assign io_out_valid = (state == SEND);
  assign xfer         = io_out_valid & io_out_ready;
  assign at_last      = (32'(k) + 32'd1) ==
                        beats_for_len(32'(head_len),
                                      32'(BEAT_BYTES));
  assign pop          = xfer & at_last & ~fifo_empty;

  // SEND whenever the FIFO will hold an entry after this edge,
  // so a push into an idle port shows beat 0 the next cycle.
  assign busy_nxt = push | (occ > OCC_W'(pop));

  always_comb begin
    keep_c = '0;
    for (int j = 0; j < BEAT_BYTES; j++) begin
      keep_c[j] = (32'(k) * 32'(BEAT_BYTES) + 32'(j))
                  < 32'(head_len);
    end
  end

  assign beat_c = head_data[32'(k) * 32'(BB_W) +: BB_W];

  assign io_out_data  = io_out_valid ? beat_c : '0;
  assign io_out_keep  = io_out_valid ? keep_c : '0;
  assign io_out_first = io_out_valid & (k == '0);
  assign io_out_last  = io_out_valid & at_last;
  assign io_phv_count = cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      k     <= '0;
      cnt   <= '0;
    end else begin
      if (xfer) begin
        if (at_last) begin
          k   <= '0;
          cnt <= cnt + CNT_W'(1);
        end else begin
          k   <= k + K_W'(1);
        end
      end
      state <= busy_nxt ? SEND : IDLE;
    end
  end

endmodule

// File: tb/tb_out_port_serializer.sv
// Directed bench for out_port_serializer with a beat scoreboard.
// Expected beats are queued at each push and popped on every transfer.
module tb_out_port_serializer;

  localparam int PB = 128;
  localparam int BB = 32;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [PB*8-1:0] in_data;
  logic [7:0]     in_len;
  logic           in_valid;
  logic           in_ready;
  logic [BB*8-1:0] out_data;
  logic [BB-1:0]  out_keep;
  logic           out_first;
  logic           out_last;
  logic           out_valid;
  logic           out_ready;
  logic [CW-1:0]  phv_count;

  typedef struct {
    logic [BB*8-1:0] data;
    logic [BB-1:0]   keep;
    logic            first;
    logic            last;
  } beat_t;

  beat_t sb[$];
  int    xfer_cyc[$];
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;

  out_port_serializer #(
    .PHV_BYTES  (PB),
    .BEAT_BYTES (BB),
    .FIFO_DEPTH (2),
    .CNT_W      (CW)
  ) dut (
    .clock           (clk),
    .reset_n         (reset_n),
    .io_phv_in_data  (in_data),
    .io_phv_in_len   (in_len),
    .io_phv_in_valid (in_valid),
    .io_phv_in_ready (in_ready),
    .io_out_data     (out_data),
    .io_out_keep     (out_keep),
    .io_out_first    (out_first),
    .io_out_last     (out_last),
    .io_out_valid    (out_valid),
    .io_out_ready    (out_ready),
    .io_phv_count    (phv_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Transfer happens at the next rising edge when valid&ready here.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      chk("sb_nonempty", 256'(sb.size() != 0), 256'(1));
      if (sb.size() != 0) begin
        beat_t e;
        e = sb.pop_front();
        chk("beat_data", out_data, e.data);
        chk("beat_keep", 256'(out_keep), 256'(e.keep));
        chk("beat_first", 256'(out_first), 256'(e.first));
        chk("beat_last", 256'(out_last), 256'(e.last));
        xfer_cyc.push_back(cyc);
      end
    end
  end

  task automatic expect_phv(input logic [PB*8-1:0] d,
                            input int len);
    int eff;
    int nb;
    beat_t b;
    eff = (len == 0) ? PB : len;
    nb  = (eff + BB - 1) / BB;
    for (int k = 0; k < nb; k++) begin
      b.data  = d[k*BB*8 +: BB*8];
      for (int j = 0; j < BB; j++)
        b.keep[j] = (k*BB + j) < eff;
      b.first = (k == 0);
      b.last  = (k == nb - 1);
      sb.push_back(b);
    end
  endtask

  function automatic logic [PB*8-1:0] rnd_phv();
    logic [PB*8-1:0] d;
    for (int i = 0; i < PB/4; i++)
      d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic offer(input logic [PB*8-1:0] d, input int len);
    int n;
    n = 0;
    in_data  = d;
    in_len   = 8'(len);
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("offer_ready", 256'(in_ready), 256'(1));
    expect_phv(d, len);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", 256'(sb.size()), 256'(0));
  endtask

  task automatic chk_consec(input string tag,
                            input int base, input int n);
    chk({tag, "_nbeats"}, 256'(xfer_cyc.size() - base), 256'(n));
    if (xfer_cyc.size() >= base + n)
      chk({tag, "_nobubble"},
          256'(xfer_cyc[base+n-1] - xfer_cyc[base]),
          256'(n - 1));
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_valid"}, 256'(out_valid), 256'(0));
    chk({tag, "_first"}, 256'(out_first), 256'(0));
    chk({tag, "_last"}, 256'(out_last), 256'(0));
    chk({tag, "_keep"}, 256'(out_keep), 256'(0));
    chk({tag, "_data"}, out_data, 256'(0));
    chk({tag, "_count"}, 256'(phv_count), 256'(0));
  endtask

  initial begin
    logic [PB*8-1:0] ramp;
    logic [BB*8-1:0] ramp0;
    logic [BB*8-1:0] snap_d;
    logic [BB-1:0]   snap_k;
    logic            snap_f;
    logic            snap_l;
    int              base;

    reset_n   = 1'b0;
    in_data   = '0;
    in_len    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < PB; i++) ramp[i*8 +: 8] = 8'(i);
    for (int i = 0; i < BB; i++) ramp0[i*8 +: 8] = 8'(i);

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_in_ready_low", 256'(in_ready), 256'(0));
    chk_idle_outs("rst");
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", 256'(in_ready), 256'(1));

    // Full PHV, ramp bytes
    base = xfer_cyc.size();
    offer(ramp, 0);
    chk("t1_valid", 256'(out_valid), 256'(1));
    chk("t1_first", 256'(out_first), 256'(1));
    chk("t1_data0", out_data, ramp0);
    drain();
    chk_consec("t1", base, 4);
    chk("t1_count", 256'(phv_count), 256'(1));

    // len=40 -> two beats, second keeps 8 bytes
    offer(rnd_phv(), 40);
    chk("t2_keep0", 256'(out_keep), 256'(32'hFFFF_FFFF));
    @(posedge clk); #1;
    chk("t2_keep1", 256'(out_keep), 256'(32'h0000_00FF));
    chk("t2_last1", 256'(out_last), 256'(1));
    drain();
    chk("t2_count", 256'(phv_count), 256'(2));

    // len=1 -> single beat
    offer(rnd_phv(), 1);
    chk("t3_first", 256'(out_first), 256'(1));
    chk("t3_last", 256'(out_last), 256'(1));
    chk("t3_keep", 256'(out_keep), 256'(1));
    drain();
    chk("t3_count", 256'(phv_count), 256'(3));

    // Back-pressure mid-PHV
    offer(rnd_phv(), 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    base   = xfer_cyc.size();
    snap_d = out_data;
    snap_k = out_keep;
    snap_f = out_first;
    snap_l = out_last;
    chk("bp_room", 256'(in_ready), 256'(1));
    in_data  = rnd_phv();
    in_len   = 8'd0;
    in_valid = 1'b1;
    expect_phv(in_data, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_valid", 256'(out_valid), 256'(1));
      chk("bp_data", out_data, snap_d);
      chk("bp_keep", 256'(out_keep), 256'(snap_k));
      chk("bp_flags", 256'({out_first, out_last}),
          256'({snap_f, snap_l}));
      chk("bp_full", 256'(in_ready), 256'(0));
    end
    out_ready = 1'b1;
    drain();
    chk_consec("bp", base, 7);
    chk("bp_count", 256'(phv_count), 256'(5));

    // Three PHVs back-to-back
    base = xfer_cyc.size();
    offer(rnd_phv(), 0);
    offer(rnd_phv(), 0);
    offer(rnd_phv(), 0);
    drain();
    chk_consec("b2b", base, 12);
    chk("b2b_count", 256'(phv_count), 256'(8));

    // Reset during beat 2
    offer(rnd_phv(), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_first", 256'(out_first), 256'(0));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", 256'(in_ready), 256'(0));
    @(posedge clk); #1;
    sb.delete();
    reset_n = 1'b1;
    #1;
    chk_idle_outs("mid_rst");
    chk("mid_rst_in_ready", 256'(in_ready), 256'(1));
    offer(rnd_phv(), 0);
    chk("fresh_first", 256'(out_first), 256'(1));
    drain();
    chk("fresh_count", 256'(phv_count), 256'(1));

    // Counter wraps after 16 PHVs
    for (int i = 0; i < 15; i++) offer(rnd_phv(), 1);
    drain();
    chk("wrap_count", 256'(phv_count), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
